// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Round-robin arbiter that shares one SRAM port between the SDRAM
//            row-cache writer (SD), the window-buffer writer (WB) and the reader (RD).
// Options  : SRAM_ARB_ADDR_CHECK_EN rejects granted addresses >= MEM_DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 16384,
    parameter int RD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sd_wr_req,
    input  logic [ADDR_W-1:0] sd_wr_addr,
    output logic              sd_wr_ack,
    input  logic              wb_wr_req,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    output logic              wb_wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              sram_enable,
    output logic              sram_mode,
    output logic              sram_addr_calc_mode,
    output logic [ADDR_W-1:0] sram_address,
    input  logic [DATA_W-1:0] sram_out_data,
    input  logic              sram_read_valid,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_READ      = 2'd2,
        S_READ_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] c_sd = 2'd0;
    localparam logic [1:0] c_wb = 2'd1;
    localparam logic [1:0] c_rd = 2'd2;

    localparam int                  c_tmo_w    = $clog2(RD_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(RD_TIMEOUT - 1);
    localparam logic [ADDR_W:0]     c_depth    = (ADDR_W + 1)'(MEM_DEPTH);
`ifdef SRAM_ARB_ADDR_CHECK_EN
    localparam bit c_check_en = 1'b1;
`else
    localparam bit c_check_en = 1'b0;
`endif

    state_t              r_state;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_gnt;
    logic                r_reject;
    logic [c_tmo_w-1:0]  r_tmo_cnt;

    logic                w_gnt_valid;
    logic [1:0]          w_gnt;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_bad;

    // Search starts at the port after the last one served: SD -> WB -> RD -> SD.
    always_comb begin
        w_gnt_valid = 1'b1;
        w_gnt       = c_sd;
        case (r_rr_ptr)
            c_sd: begin
                if (wb_wr_req)      w_gnt = c_wb;
                else if (rd_req)    w_gnt = c_rd;
                else if (sd_wr_req) w_gnt = c_sd;
                else                w_gnt_valid = 1'b0;
            end
            c_wb: begin
                if (rd_req)         w_gnt = c_rd;
                else if (sd_wr_req) w_gnt = c_sd;
                else if (wb_wr_req) w_gnt = c_wb;
                else                w_gnt_valid = 1'b0;
            end
            default: begin
                if (sd_wr_req)      w_gnt = c_sd;
                else if (wb_wr_req) w_gnt = c_wb;
                else if (rd_req)    w_gnt = c_rd;
                else                w_gnt_valid = 1'b0;
            end
        endcase

        case (w_gnt)
            c_sd:    w_gnt_addr = sd_wr_addr;
            c_wb:    w_gnt_addr = wb_wr_addr;
            default: w_gnt_addr = rd_addr;
        endcase

        w_bad = c_check_en && ({1'b0, w_gnt_addr} >= c_depth);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_rr_ptr            <= c_rd;
            r_gnt               <= c_sd;
            r_reject            <= 1'b0;
            r_tmo_cnt           <= '0;
            sd_wr_ack           <= 1'b0;
            wb_wr_ack           <= 1'b0;
            rd_ack              <= 1'b0;
            rd_data             <= '0;
            rd_data_valid       <= 1'b0;
            sram_enable         <= 1'b0;
            sram_mode           <= 1'b0;
            sram_addr_calc_mode <= 1'b0;
            sram_address        <= '0;
            err                 <= 1'b0;
        end else begin
            sd_wr_ack           <= 1'b0;
            wb_wr_ack           <= 1'b0;
            rd_ack              <= 1'b0;
            rd_data_valid       <= 1'b0;
            err                 <= 1'b0;
            sram_enable         <= 1'b0;
            sram_mode           <= 1'b0;
            sram_addr_calc_mode <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt    <= w_gnt;
                        r_reject <= w_bad;
                        err      <= w_bad;
                        if (!w_bad) begin
                            sram_enable  <= 1'b1;
                            sram_address <= w_gnt_addr;
                        end
                        case (w_gnt)
                            c_sd: begin
                                sd_wr_ack           <= 1'b1;
                                sram_addr_calc_mode <= ~w_bad;
                                r_state             <= S_WRITE;
                            end
                            c_wb: begin
                                wb_wr_ack <= 1'b1;
                                r_state   <= S_WRITE;
                            end
                            default: begin
                                rd_ack    <= 1'b1;
                                sram_mode <= ~w_bad;
                                r_state   <= S_READ;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_rr_ptr <= r_gnt;
                    r_state  <= S_IDLE;
                end

                S_READ: begin
                    r_rr_ptr  <= c_rd;
                    r_tmo_cnt <= '0;
                    // A rejected read never reached the SRAM; answer it with zero now.
                    if (r_reject) begin
                        rd_data       <= '0;
                        rd_data_valid <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_state <= S_READ_WAIT;
                    end
                end

                S_READ_WAIT: begin
                    if (sram_read_valid) begin
                        rd_data       <= sram_out_data;
                        rd_data_valid <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        rd_data       <= '0;
                        rd_data_valid <= 1'b1;
                        err           <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random request traffic checked
// against a transaction-level schedule model (round-robin order, fixed latencies).
`default_nettype none

module tb_sram_arbiter;
    localparam int ADDR_W     = 26;
    localparam int DATA_W     = 32;
    localparam int MEM_DEPTH  = 16384;
    localparam int RD_TIMEOUT = 4;
`ifdef SRAM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sd_wr_req = 1'b0;
    logic [ADDR_W-1:0] sd_wr_addr = '0;
    logic              sd_wr_ack;
    logic              wb_wr_req = 1'b0;
    logic [ADDR_W-1:0] wb_wr_addr = '0;
    logic              wb_wr_ack;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              sram_enable;
    logic              sram_mode;
    logic              sram_addr_calc_mode;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_out_data = '0;
    logic              sram_read_valid = 1'b0;
    logic              err;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .sd_wr_req(sd_wr_req), .sd_wr_addr(sd_wr_addr), .sd_wr_ack(sd_wr_ack),
        .wb_wr_req(wb_wr_req), .wb_wr_addr(wb_wr_addr), .wb_wr_ack(wb_wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .sram_enable(sram_enable), .sram_mode(sram_mode),
        .sram_addr_calc_mode(sram_addr_calc_mode), .sram_address(sram_address),
        .sram_out_data(sram_out_data), .sram_read_valid(sram_read_valid), .err(err)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
        if (a == 26'h20) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // SRAM read model: valid is presented in the cycle after the enable cycle.
    bit          resp_en = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    always @(posedge clk) begin
        #1;
        sram_read_valid = pend;
        sram_out_data   = pend ? pend_data : 32'hBAD0_BAD0;
        pend            = resp_en && sram_enable && sram_mode;
        pend_data       = word(sram_address);
    end

    logic              preq [3];
    logic [ADDR_W-1:0] paddr[3];
    bit                rand_mode = 1'b0;
    bit                hold_all  = 1'b0;

    int                last, free_in, rv_cnt;
    logic [31:0]       rv_data, e_rdata;
    logic              rv_err;
    logic              e_ack[3];
    logic              e_en, e_mode, e_calc, e_rv, e_err, prev_en;
    logic [ADDR_W-1:0] e_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        sd_wr_req = preq[0]; sd_wr_addr = paddr[0];
        wb_wr_req = preq[1]; wb_wr_addr = paddr[1];
        rd_req    = preq[2]; rd_addr    = paddr[2];
    endtask

    task automatic reset_model();
        last = 2; free_in = 0; rv_cnt = 0;
        rv_data = '0; rv_err = 1'b0; e_rdata = '0;
        for (int p = 0; p < 3; p++) e_ack[p] = 1'b0;
        e_en = 0; e_mode = 0; e_calc = 0; e_rv = 0; e_err = 0; prev_en = 0;
        e_addr = '0;
    endtask

    // Expected outputs after the coming edge, from the current request set.
    task automatic predict();
        int g;
        bit bad;
        for (int p = 0; p < 3; p++) e_ack[p] = 1'b0;
        e_en = 0; e_mode = 0; e_calc = 0; e_rv = 0; e_err = 0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                e_rv = 1'b1; e_rdata = rv_data; e_err = rv_err;
            end
        end
        if (free_in > 0) begin
            free_in--;
        end else begin
            g = -1;
            for (int i = 1; i <= 3; i++) begin
                int p;
                p = (last + i) % 3;
                if (g < 0 && preq[p]) g = p;
            end
            if (g >= 0) begin
                bad = CHECK_EN && (int'(paddr[g]) >= MEM_DEPTH);
                e_ack[g] = 1'b1;
                last = g;
                if (bad) e_err = 1'b1;
                else begin
                    e_en = 1'b1; e_addr = paddr[g];
                    e_mode = (g == 2); e_calc = (g == 0);
                end
                if (g == 2) begin
                    if (bad) begin
                        rv_cnt = 1; rv_data = '0; rv_err = 1'b0; free_in = 1;
                    end else if (resp_en) begin
                        rv_cnt = 2; rv_data = word(paddr[g]); rv_err = 1'b0; free_in = 2;
                    end else begin
                        rv_cnt = 1 + RD_TIMEOUT; rv_data = '0; rv_err = 1'b1;
                        free_in = 1 + RD_TIMEOUT;
                    end
                end else begin
                    free_in = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("sd_wr_ack", sd_wr_ack, e_ack[0]);
        chk("wb_wr_ack", wb_wr_ack, e_ack[1]);
        chk("rd_ack", rd_ack, e_ack[2]);
        chk("sram_enable", sram_enable, e_en);
        chk("sram_address", sram_address, e_addr);
        if (e_en) begin
            chk("sram_mode", sram_mode, e_mode);
            chk("sram_addr_calc_mode", sram_addr_calc_mode, e_calc);
        end
        chk("rd_data_valid", rd_data_valid, e_rv);
        if (e_rv) chk("rd_data", rd_data, e_rdata);
        chk("err", err, e_err);
        chk("enable_adjacent", prev_en & sram_enable, 1'b0);
        prev_en = sram_enable;
    endtask

    task automatic cyc();
        if (rand_mode) begin
            for (int p = 0; p < 3; p++) begin
                if (!preq[p] && $urandom_range(0, 2) == 0) begin
                    preq[p]  = 1'b1;
                    paddr[p] = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
                end
            end
        end
        drive();
        predict();
        @(posedge clk);
        #1;
        check_outputs();
        if (!hold_all) for (int p = 0; p < 3; p++) if (e_ack[p]) preq[p] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sd_ack"}, sd_wr_ack, 1'b0);
        chk({tag, "_wb_ack"}, wb_wr_ack, 1'b0);
        chk({tag, "_rd_ack"}, rd_ack, 1'b0);
        chk({tag, "_rd_data"}, rd_data, '0);
        chk({tag, "_rd_data_valid"}, rd_data_valid, 1'b0);
        chk({tag, "_enable"}, sram_enable, 1'b0);
        chk({tag, "_mode"}, sram_mode, 1'b0);
        chk({tag, "_calc_mode"}, sram_addr_calc_mode, 1'b0);
        chk({tag, "_address"}, sram_address, '0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < 3; p++) begin preq[p] = 1'b0; paddr[p] = '0; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        reset_model();
    endtask

    int q[$];

    initial begin
        do_reset();

        // Single SD write
        preq[0] = 1'b1; paddr[0] = 26'h10;
        cyc();
        chk("sd_write_ack", sd_wr_ack, 1'b1);
        chk("sd_write_calc", sram_addr_calc_mode, 1'b1);
        chk("sd_write_addr", sram_address, 26'h10);
        cyc();
        chk("sd_write_enable_low", sram_enable, 1'b0);
        repeat (2) cyc();

        // WB write then read back 0x20
        preq[1] = 1'b1; paddr[1] = 26'h20;
        repeat (2) cyc();
        preq[2] = 1'b1; paddr[2] = 26'h20;
        cyc();
        chk("read_ack_p1", rd_ack, 1'b1);
        repeat (2) cyc();
        chk("read_valid_p3", rd_data_valid, 1'b1);
        chk("read_data_beef", rd_data, 32'hDEADBEEF);
        repeat (2) cyc();

        // All three held: strict rotation SD, WB, RD, ...
        do_reset();
        hold_all = 1'b1;
        for (int p = 0; p < 3; p++) begin preq[p] = 1'b1; paddr[p] = ADDR_W'(32'h100 + p); end
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (sd_wr_ack) q.push_back(0);
            if (wb_wr_ack) q.push_back(1);
            if (rd_ack)    q.push_back(2);
        end
        chk("rotation_grants_ge4", q.size() >= 4, 1'b1);
        for (int k = 0; k < q.size(); k++) chk("rotation_order", q[k], k % 3);
        hold_all = 1'b0;
        for (int p = 0; p < 3; p++) preq[p] = 1'b0;
        repeat (8) cyc();

        // Read timeout, then the pending WB write is served
        resp_en = 1'b0;
        preq[2] = 1'b1; paddr[2] = 26'h44;
        cyc();
        chk("timeout_rd_ack", rd_ack, 1'b1);
        preq[1] = 1'b1; paddr[1] = 26'h50;
        repeat (RD_TIMEOUT + 1) cyc();
        chk("timeout_valid", rd_data_valid, 1'b1);
        chk("timeout_data", rd_data, '0);
        chk("timeout_err", err, 1'b1);
        cyc();
        chk("after_timeout_wb_ack", wb_wr_ack, 1'b1);
        resp_en = 1'b1;
        repeat (3) cyc();

        // Asynchronous reset while in READ_WAIT
        preq[2] = 1'b1; paddr[2] = 26'h60;
        repeat (2) cyc();
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        preq[0] = 1'b1; paddr[0] = 26'h30;
        preq[2] = 1'b1; paddr[2] = 26'h40;
        @(posedge clk);
        #1;
        chk("no_rdv_during_rst", rd_data_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        cyc();
        chk("first_grant_after_rst_sd", sd_wr_ack, 1'b1);
        repeat (6) cyc();

`ifdef SRAM_ARB_ADDR_CHECK_EN
        preq[1] = 1'b1; paddr[1] = 26'h4000;
        cyc();
        chk("range_wb_ack", wb_wr_ack, 1'b1);
        chk("range_wb_err", err, 1'b1);
        chk("range_wb_enable", sram_enable, 1'b0);
        cyc();
        preq[2] = 1'b1; paddr[2] = 26'h5000;
        cyc();
        chk("range_rd_err", err, 1'b1);
        cyc();
        chk("range_rd_valid", rd_data_valid, 1'b1);
        chk("range_rd_data", rd_data, '0);
        repeat (2) cyc();
`endif

        // Random request traffic
        rand_mode = 1'b1;
        repeat (600) cyc();
        rand_mode = 1'b0;
        for (int p = 0; p < 3; p++) preq[p] = 1'b0;
        repeat (8) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
